inspection_input_conditioner: RTL and testbench
===============================================

Name: inspection_input_conditioner

Overview:
Upstream front-end of the quality-classification FSM. Synchronises and debounces three raw pass/fail sensor lines (weight, size, colour) and an item-present sensor. Captures one clean snapshot per item and offers it downstream through a valid/ready handshake. Also keeps a wrap-around count of items delivered and flags items removed before capture.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronised cycles a raw line must differ from its debounced value before the debounced value flips (>=1).
SETTLE_CYCLES, 8, cycles after item detection before the three sensor bits are captured (>=1).

Ports:
clk  input  1  system clock; all flops on rising edge.
rst  input  1  asynchronous, active-high reset.
weight_raw_i  input  1  raw weight-ok sensor, asynchronous to clk.
size_raw_i  input  1  raw size-ok sensor, asynchronous.
color_raw_i  input  1  raw colour-ok sensor, asynchronous.
item_raw_i  input  1  raw item-present sensor, asynchronous.
sample_ready_i  input  1  downstream FSM accepts the snapshot.
sample_valid_o  output  1  snapshot on *_ok_o is valid.
weight_ok_o  output  1  captured weight result.
size_ok_o  output  1  captured size result.
color_ok_o  output  1  captured colour result.
abort_o  output  1  one-cycle pulse: item lost during SETTLE.
item_count_o  output  8  number of accepted snapshots, mod 256.
state_o  output  2  IDLE=0, SETTLE=1, VALID=2, WAIT_CLEAR=3.

Behaviour:
- Reset (async assert, sync release is the integrator's concern): all sync flops, debounced values, counters and outputs go to 0. state_o=IDLE.
- Sync: each raw line passes through a 2-flop synchroniser (2-cycle latency).
- Debounce, per line, independent counter of width clog2(DEBOUNCE_CYCLES+1):
  - sync==deb: counter cleared.
  - sync!=deb: counter increments.
  - On the edge completing DEBOUNCE_CYCLES consecutive differing cycles, deb<=sync and counter clears.
  - Any single-cycle agreement restarts the count.
  - Raw step to deb change = 2+DEBOUNCE_CYCLES cycles.
- FSM, on debounced item (item_db):
  - IDLE: item_db=1 -> SETTLE, settle counter=0.
  - SETTLE: counter increments each cycle.
    - item_db=0 -> IDLE; abort_o=1 for exactly the next cycle; no capture, no count.
    - Else, on the edge where counter==SETTLE_CYCLES-1 -> VALID; that edge registers debounced weight/size/color into *_ok_o and sets sample_valid_o=1.
    - Abort has priority if both occur on the same edge.
  - VALID: *_ok_o and sample_valid_o held constant regardless of sensor or item changes.
    - Transfer on an edge with sample_valid_o=1 and sample_ready_i=1 -> WAIT_CLEAR; sample_valid_o<=0; item_count_o increments (255 wraps to 0).
    - sample_ready_i may be high before valid; transfer then occurs on the first edge valid is high (SETTLE_CYCLES cycles after entering SETTLE).
  - WAIT_CLEAR: *_ok_o keep last captured values; item_db=0 -> IDLE. Blocks re-trigger by the same item.
  - Item removal during VALID does not cancel the snapshot.
- sample_valid_o and *_ok_o change only in the transitions above. No combinational path from inputs to outputs.
- Reset mid-operation: immediate return to the reset state. A pending snapshot is discarded, and the count is cleared.

Test Plan:
- DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3: reset, then hold all raw=0 for 20 cycles -> all outputs 0, state_o=0.
- Debounce, DEBOUNCE_CYCLES=4: weight_raw_i 1 for 3 cycles then 0 -> deb never changes. Held 1 -> deb rises 6 cycles after the raw edge. Glitch of 1 cycle mid-count restarts the count.
- Normal item: weight=1, size=0, color=1, item_raw 1 held, ready=0 -> state 1 for 3 cycles, then valid=1, ok bits=1,0,1, held for 10 cycles. Ready=1 for 1 cycle -> valid=0 next cycle, count=1, state 3. item_raw 0 -> state 0 after debounce.
- Abort: item_raw drops so item_db falls during SETTLE -> abort_o high exactly 1 cycle, valid never asserts, count unchanged, state 0.
- Ready pre-asserted and sensor change in VALID: ready=1 throughout -> valid high exactly 1 cycle. color_raw flipping during VALID does not alter color_ok_o. 256 items -> count wraps to 0.
- Async reset asserted in VALID, mid-cycle -> outputs 0 immediately, before the next clock edge. After release, the held item re-enters SETTLE.

Source files
------------

// File: rtl/inspection_input_conditioner.sv
// Input conditioner for the quality-classification FSM: synchronises and
// debounces the weight/size/colour/item sensor lines, captures one snapshot
// per item after a settle delay and offers it downstream.
//
// Handshake: sample_valid_o rises together with the captured *_ok_o bits and
// stays high, with the bits frozen, until a rising edge where
// sample_ready_i is also high; that edge is the transfer and clears
// sample_valid_o. sample_ready_i may be high before valid rises.
module inspection_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       weight_raw_i,
  input  logic       size_raw_i,
  input  logic       color_raw_i,
  input  logic       item_raw_i,
  input  logic       sample_ready_i,
  output logic       sample_valid_o,
  output logic       weight_ok_o,
  output logic       size_ok_o,
  output logic       color_ok_o,
  output logic       abort_o,
  output logic [7:0] item_count_o,
  output logic [1:0] state_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETTLE     = 2'd1,
    VALID      = 2'd2,
    WAIT_CLEAR = 2'd3
  } state_t;

  // Line index: 0 weight, 1 size, 2 colour, 3 item present.
  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb_q, deb_d;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic item_db;

  state_t     state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic       valid_q, valid_d;
  logic [2:0] ok_q, ok_d;
  logic       abort_q, abort_d;
  logic [7:0] count_q, count_d;

  assign raw     = {item_raw_i, color_raw_i, size_raw_i, weight_raw_i};
  assign item_db = deb_q[3];

  // Per-line debounce: count consecutive disagreeing cycles, flip on the last one.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Synchroniser and debounce registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Next-state and output logic for the capture FSM.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    valid_d  = valid_q;
    ok_d     = ok_q;
    abort_d  = 1'b0;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (item_db) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        // Losing the item wins over completing the settle time.
        if (!item_db) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = VALID;
          valid_d = 1'b1;
          ok_d    = deb_q[2:0];
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      VALID: begin
        // Item removal here does not cancel the snapshot.
        if (sample_ready_i) begin
          state_d = WAIT_CLEAR;
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
        end
      end
      WAIT_CLEAR: begin
        // Hold off until the item leaves so it is not captured twice.
        if (!item_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      valid_q  <= 1'b0;
      ok_q     <= '0;
      abort_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      valid_q  <= valid_d;
      ok_q     <= ok_d;
      abort_q  <= abort_d;
      count_q  <= count_d;
    end
  end

  assign sample_valid_o = valid_q;
  assign weight_ok_o    = ok_q[0];
  assign size_ok_o      = ok_q[1];
  assign color_ok_o     = ok_q[2];
  assign abort_o        = abort_q;
  assign item_count_o   = count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_inspection_input_conditioner.sv
// Bench for inspection_input_conditioner. u_dut uses DEBOUNCE=4, SETTLE=3;
// u_dut2 uses SETTLE=8 so an item can be lost while still settling.
module tb_inspection_input_conditioner;

  localparam int D = 4;
  localparam int S = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic weight_raw, size_raw, color_raw, item_raw, ready;
  logic item2_raw, ready2;

  logic       valid, w_ok, s_ok, c_ok, abort;
  logic [7:0] count;
  logic [1:0] state;
  logic       valid2, w_ok2, s_ok2, c_ok2, abort2;
  logic [7:0] count2;
  logic [1:0] state2;

  inspection_input_conditioner #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst),
    .weight_raw_i(weight_raw), .size_raw_i(size_raw), .color_raw_i(color_raw),
    .item_raw_i(item_raw), .sample_ready_i(ready),
    .sample_valid_o(valid), .weight_ok_o(w_ok), .size_ok_o(s_ok), .color_ok_o(c_ok),
    .abort_o(abort), .item_count_o(count), .state_o(state)
  );

  inspection_input_conditioner #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .weight_raw_i(weight_raw), .size_raw_i(size_raw), .color_raw_i(color_raw),
    .item_raw_i(item2_raw), .sample_ready_i(ready2),
    .sample_valid_o(valid2), .weight_ok_o(w_ok2), .size_ok_o(s_ok2), .color_ok_o(c_ok2),
    .abort_o(abort2), .item_count_o(count2), .state_o(state2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];   // {weight, size, colour}
  logic [2:0] exp_snap;
  logic [7:0] exp_count;

  // A transfer happens on the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got snapshot %b, no snapshot expected", {w_ok, s_ok, c_ok});
      end else begin
        exp_snap = exp_q.pop_front();
        if ({w_ok, s_ok, c_ok} !== exp_snap) begin
          n_fail++;
          $display("FAIL scoreboard_snapshot: got %b expected %b", {w_ok, s_ok, c_ok}, exp_snap);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    exp_count = 8'd0;
  endtask

  task automatic set_sensors(input logic w, input logic s, input logic c);
    weight_raw = w;
    size_raw   = s;
    color_raw  = c;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (state === target) break;
      tick();
    end
    n_checks++;
    if (state !== target) begin
      n_fail++;
      $display("FAIL %s: state %0d, required %0d within %0d cycles", name, state, target, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad = 0;
    do_reset();
    set_sensors(1'b0, 1'b0, 1'b0);
    item_raw = 1'b0;
    ready    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({valid, w_ok, s_ok, c_ok, abort, count, state} !== 15'd0) begin
        n_fail++;
        bad++;
        if (bad < 4) $display("FAIL reset_idle: outputs %b, required all 0", {valid, w_ok, s_ok, c_ok, abort, count, state});
      end
      tick();
    end
  endtask

  task automatic test_debounce();
    int bad = 0;
    ready = 1'b1;
    set_sensors(1'b0, 1'b1, 1'b1);
    tick(8);
    // Pulse of 3 cycles is too short to pass the filter.
    item_raw = 1'b1;
    tick(3);
    item_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (state !== 2'd0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL debounce_short_pulse: state left IDLE %0d times, required 0", bad);
    end
    // Held step: debounced item at edge 6, FSM in SETTLE after edge 7.
    item_raw = 1'b1;
    exp_q.push_back(3'b011);
    tick(6);
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL debounce_step_early: state %0d at edge 6, required 0", state);
    end
    tick();
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL debounce_step_latency: state %0d at edge 7, required 1", state);
    end
    wait_state(2'd3, 20, "debounce_step_done");
    exp_count++;
    item_raw = 1'b0;
    wait_state(2'd0, 20, "debounce_step_clear");
    tick(4);
    // Glitch at the fourth cycle restarts the count from the new rise.
    item_raw = 1'b1;
    exp_q.push_back(3'b011);
    tick(3);
    item_raw = 1'b0;
    tick();
    item_raw = 1'b1;
    tick(6);
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL debounce_glitch_restart: state %0d at edge 10, required 0", state);
    end
    tick();
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL debounce_glitch_latency: state %0d at edge 11, required 1", state);
    end
    wait_state(2'd3, 20, "debounce_glitch_done");
    exp_count++;
    item_raw = 1'b0;
    wait_state(2'd0, 20, "debounce_glitch_clear");
    ready = 1'b0;
  endtask

  task automatic test_normal();
    int bad = 0;
    set_sensors(1'b1, 1'b0, 1'b1);
    item_raw = 1'b1;
    exp_q.push_back(3'b101);
    wait_state(2'd1, 20, "normal_settle_entry");
    for (int i = 0; i < S; i++) begin
      n_checks++;
      if (state !== 2'd1 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL normal_settle: state %0d valid %b, required 1 and 0", state, valid);
      end
      tick();
    end
    n_checks++;
    if (state !== 2'd2 || valid !== 1'b1 || {w_ok, s_ok, c_ok} !== 3'b101) begin
      n_fail++;
      $display("FAIL normal_capture: state %0d valid %b ok %b, required 2 1 101", state, valid, {w_ok, s_ok, c_ok});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state !== 2'd2 || valid !== 1'b1 || {w_ok, s_ok, c_ok} !== 3'b101) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL normal_hold: snapshot disturbed in %0d of 10 cycles, required 0", bad);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    exp_count++;
    n_checks++;
    if (valid !== 1'b0 || count !== exp_count || state !== 2'd3) begin
      n_fail++;
      $display("FAIL normal_transfer: valid %b count %0d state %0d, required 0 %0d 3", valid, count, state, exp_count);
    end
    item_raw = 1'b0;
    wait_state(2'd0, 20, "normal_clear");
  endtask

  task automatic test_abort();
    int aborts = 0;
    int valids = 0;
    item2_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (state2 === 2'd1) break;
      tick();
    end
    n_checks++;
    if (state2 !== 2'd1) begin
      n_fail++;
      $display("FAIL abort_settle_entry: state %0d, required 1", state2);
    end
    item2_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (abort2 === 1'b1) aborts++;
      if (valid2 === 1'b1) valids++;
    end
    n_checks++;
    if (aborts != 1) begin
      n_fail++;
      $display("FAIL abort_pulse: abort high %0d cycles, required 1", aborts);
    end
    n_checks++;
    if (valids != 0 || count2 !== 8'd0 || state2 !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_no_capture: valid cycles %0d count %0d state %0d, required 0 0 0", valids, count2, state2);
    end
  endtask

  task automatic test_color_hold();
    int bad = 0;
    ready = 1'b0;
    set_sensors(1'b0, 1'b1, 1'b0);
    item_raw = 1'b1;
    exp_q.push_back(3'b010);
    wait_state(2'd2, 30, "hold_valid");
    // Colour flips and the item leaves while the snapshot waits.
    color_raw = 1'b1;
    item_raw  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (c_ok !== 1'b0 || valid !== 1'b1 || state !== 2'd2) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_color_frozen: snapshot changed in %0d of 12 cycles, required 0", bad);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    exp_count++;
    n_checks++;
    if (state !== 2'd3 || count !== exp_count) begin
      n_fail++;
      $display("FAIL hold_transfer: state %0d count %0d, required 3 %0d", state, count, exp_count);
    end
    tick();
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL hold_wait_clear: state %0d, required 0", state);
    end
    color_raw = 1'b0;
    tick(8);
  endtask

  task automatic test_ready_early();
    int valid_cycles = 0;
    ready = 1'b1;
    set_sensors(1'b1, 1'b1, 1'b1);
    item_raw = 1'b1;
    exp_q.push_back(3'b111);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid === 1'b1) valid_cycles++;
      if (state === 2'd3) break;
    end
    exp_count++;
    n_checks++;
    if (valid_cycles != 1 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL ready_early_valid: valid cycles %0d state %0d, required 1 and 3", valid_cycles, state);
    end
    n_checks++;
    if (count !== exp_count) begin
      n_fail++;
      $display("FAIL ready_early_count: count %0d, required %0d", count, exp_count);
    end
    item_raw = 1'b0;
    wait_state(2'd0, 20, "ready_early_clear");
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_sensors(1'b1, 1'b0, 1'b0);
    item_raw = 1'b1;
    exp_q.push_back(3'b100);
    wait_state(2'd2, 30, "reset_mid_valid");
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid, w_ok, s_ok, c_ok, abort, count, state} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: outputs %b, required all 0 before next edge", {valid, w_ok, s_ok, c_ok, abort, count, state});
    end
    exp_q.delete();
    exp_count = 8'd0;
    tick(2);
    rst = 1'b0;
    wait_state(2'd1, 20, "reset_mid_reenter");
    exp_q.push_back(3'b100);
    ready = 1'b1;
    wait_state(2'd3, 20, "reset_mid_transfer");
    exp_count++;
    n_checks++;
    if (count !== exp_count) begin
      n_fail++;
      $display("FAIL reset_mid_count: count %0d, required %0d", count, exp_count);
    end
    ready = 1'b0;
    item_raw = 1'b0;
    wait_state(2'd0, 20, "reset_mid_clear");
  endtask

  task automatic test_wrap();
    logic [2:0] bits;
    do_reset();
    ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      bits = 3'($urandom_range(0, 7));
      set_sensors(bits[2], bits[1], bits[0]);
      item_raw = 1'b1;
      exp_q.push_back(bits);
      wait_state(2'd3, 30, "wrap_transfer");
      exp_count++;
      item_raw = 1'b0;
      wait_state(2'd0, 30, "wrap_clear");
      if (n == 254) begin
        n_checks++;
        if (count !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_count_255: count %0d, required 255", count);
        end
      end
    end
    n_checks++;
    if (count !== exp_count || exp_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_count_zero: count %0d, required 0", count);
    end
    ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    set_sensors(1'b0, 1'b0, 1'b0);
    item_raw  = 1'b0;
    item2_raw = 1'b0;
    ready     = 1'b0;
    ready2    = 1'b0;
    exp_count = 8'd0;
    test_reset();
    test_debounce();
    test_normal();
    test_abort();
    test_color_hold();
    test_ready_early();
    test_reset_mid();
    test_wrap();
    tick(4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d snapshots never delivered, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
